lfsr_ber_checker: RTL and testbench

LFSR_BER_CHECKER -- requirements
Module: lfsr_ber_checker

---
 rtl/lfsr_ber_checker_pkg.sv | 30 +++
 rtl/lfsr_ber_checker_gen.sv | 36 +++
 rtl/lfsr_ber_checker.sv | 182 ++++++++++++++++++
 tb/tb_lfsr_ber_checker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_ber_checker_pkg.sv
// Shared definitions for the PRBS-22 bit-error-rate checker: state encoding,
// feedback tap positions, symbol width and small helpers.
package lfsr_ber_checker_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_BAD    = 2'd3
  } state_e;

  localparam int SYM_W = 2;
  localparam int CNT_W = 32;

  // Feedback taps as offsets from the register length: s[LEN-1] ^ s[LEN-2].
  localparam int TAP_HI_OFS = 1;
  localparam int TAP_LO_OFS = 2;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic logic [1:0] bit_errs(input logic [SYM_W-1:0] a,
                                          input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] d;
    d = a ^ b;
    return {1'b0, d[0]} + {1'b0, d[1]};
  endfunction

endpackage

// File: rtl/lfsr_ber_checker_gen.sv
// Local copy of the transmitter LFSR: load-shift mode during fill, free-running
// advance mode while checking; predicts the next transmitted symbol.
module lfsr_local_gen
  import lfsr_ber_checker_pkg::*;
#(
  parameter int LEN = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic             bit_i,
  output logic [SYM_W-1:0] pred_o,
  output logic             load_zero_o
);

  logic [LEN-1:0] s_q, s_d;
  logic           fb;

  assign fb          = s_q[LEN-TAP_HI_OFS] ^ s_q[LEN-TAP_LO_OFS];
  // Predicted symbol is s[1:0] of the register after one advance.
  assign pred_o      = {s_q[0], fb};
  assign load_zero_o = ({s_q[LEN-2:0], bit_i} == '0);

  always_comb begin
    s_d = s_q;
    if (load_i)     s_d = {s_q[LEN-2:0], bit_i};
    else if (adv_i) s_d = {s_q[LEN-2:0], fb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= '0;
    else        s_q <= s_d;
  end

endmodule

// File: rtl/lfsr_ber_checker.sv
// PRBS-22 4-ASK in-phase checker: fills a local LFSR from received bits,
// qualifies lock over a window, then counts bit/symbol errors while locked.
module lfsr_ber_checker
  import lfsr_ber_checker_pkg::*;
#(
  parameter int LFSR_LEN    = 22,
  parameter int WIN_LEN     = 256,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic [SYM_W-1:0] rx_sym,
  input  logic             clear,
  output logic             locked,
  output logic [1:0]       state,
  output logic             sym_err,
  output logic             slip,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sym_count
);

  localparam int FW = cnt_w(LFSR_LEN);
  localparam int WW = cnt_w(WIN_LEN);
  localparam int MW = cnt_w((WIN_LEN > LOSS_THRESH ? WIN_LEN : LOSS_THRESH) + 1);

  localparam logic [FW-1:0] FILL_LAST = FW'(LFSR_LEN - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_LEN - 1);
  localparam logic [MW-1:0] THRESH    = MW'(LOSS_THRESH);

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WW-1:0]    win_q, win_d;
  logic [MW-1:0]    mis_q, mis_d;
  logic             zero_q, zero_d;
  logic             sym_err_q, sym_err_d;
  logic             slip_q, slip_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] symc_q, symc_d;

  logic             gen_load, gen_adv, load_zero;
  logic [SYM_W-1:0] pred;
  logic             mismatch;
  logic [1:0]       nbits;
  logic [MW-1:0]    mis_nxt;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_inc, symc_inc;

  lfsr_local_gen #(.LEN(LFSR_LEN)) u_gen (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (gen_load),
    .adv_i      (gen_adv),
    .bit_i      (rx_sym[0]),
    .pred_o     (pred),
    .load_zero_o(load_zero)
  );

  assign mismatch = |(pred ^ rx_sym);
  assign nbits    = bit_errs(pred, rx_sym);
  assign mis_nxt  = mis_q + MW'(mismatch);

  // Both counters stick at all-ones instead of wrapping.
  assign err_sum  = {1'b0, err_q} + {{(CNT_W-1){1'b0}}, nbits};
  assign err_inc  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  assign symc_inc = (&symc_q) ? symc_q : symc_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    win_d     = win_q;
    mis_d     = mis_q;
    zero_d    = zero_q;
    sym_err_d = 1'b0;
    slip_d    = 1'b0;
    err_d     = err_q;
    symc_d    = symc_q;
    gen_load  = 1'b0;
    gen_adv   = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (clk_en) begin
          gen_load = 1'b1;
          if (fill_q == FILL_LAST) begin
            state_d = ST_QUAL;
            fill_d  = '0;
            win_d   = '0;
            mis_d   = '0;
            zero_d  = load_zero;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
      end

      ST_QUAL: begin
        if (clk_en) begin
          gen_adv   = 1'b1;
          sym_err_d = mismatch;
          if (win_q == WIN_LAST) begin
            // A zero register locks onto an all-zero stream; never accept it.
            state_d = (mis_nxt <= THRESH && !zero_q) ? ST_LOCKED : ST_FILL;
            fill_d  = '0;
            win_d   = '0;
            mis_d   = '0;
          end else begin
            win_d = win_q + WW'(1);
            mis_d = mis_nxt;
          end
        end
      end

      ST_LOCKED: begin
        if (clk_en) begin
          gen_adv   = 1'b1;
          sym_err_d = mismatch;
          err_d     = err_inc;
          symc_d    = symc_inc;
          if (mis_nxt > THRESH) begin
            state_d = ST_FILL;
            slip_d  = 1'b1;
            fill_d  = '0;
            win_d   = '0;
            mis_d   = '0;
          end else if (win_q == WIN_LAST) begin
            win_d = '0;
            mis_d = '0;
          end else begin
            win_d = win_q + WW'(1);
            mis_d = mis_nxt;
          end
        end
      end

      default: begin
        state_d = ST_FILL;
        fill_d  = '0;
        win_d   = '0;
        mis_d   = '0;
      end
    endcase

    // clear is a host control, independent of the symbol strobe.
    if (clear) begin
      err_d  = '0;
      symc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FILL;
      fill_q    <= '0;
      win_q     <= '0;
      mis_q     <= '0;
      zero_q    <= 1'b0;
      sym_err_q <= 1'b0;
      slip_q    <= 1'b0;
      err_q     <= '0;
      symc_q    <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      win_q     <= win_d;
      mis_q     <= mis_d;
      zero_q    <= zero_d;
      sym_err_q <= sym_err_d;
      slip_q    <= slip_d;
      err_q     <= err_d;
      symc_q    <= symc_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign state     = state_q;
  assign sym_err   = sym_err_q;
  assign slip      = slip_q;
  assign err_count = err_q;
  assign sym_count = symc_q;

endmodule

// File: tb/tb_lfsr_ber_checker.sv
// Bench for lfsr_ber_checker: PRBS-22 source, sequence-recurrence reference
// model compared every cycle, plus directed literal checks.
module tb_lfsr_ber_checker;

  localparam int LEN = 22;
  localparam int WIN = 256;
  localparam int TH  = 8;
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  rx_sym = 2'b00;
  logic        locked, sym_err, slip;
  logic [1:0]  state;
  logic [31:0] err_count, sym_count;

  lfsr_ber_checker #(.LFSR_LEN(LEN), .WIN_LEN(WIN), .LOSS_THRESH(TH)) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .rx_sym   (rx_sym),
    .clear    (clear),
    .locked   (locked),
    .state    (state),
    .sym_err  (sym_err),
    .slip     (slip),
    .err_count(err_count),
    .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. The transmitted bit stream obeys c[k+1] = c[k-21] ^ c[k-20];
  // the model keeps the last 22 bits of the expected stream and predicts from it.
  int      m_mode, m_fill, m_win, m_mis, m_nerr;
  bit      m_zero, m_sym_err, m_slip, m_nb;
  bit [1:0] m_pred;
  longint  m_err, m_sym;
  bit      seq[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_fill = 0; m_win = 0; m_mis = 0; m_zero = 0;
      m_sym_err = 0; m_slip = 0; m_err = 0; m_sym = 0;
      seq.delete();
      for (int i = 0; i < LEN; i++) seq.push_back(1'b0);
    end else begin
      m_sym_err = 0;
      m_slip = 0;
      if (clk_en) begin
        if (m_mode == 0) begin
          seq.push_back(rx_sym[0]);
          void'(seq.pop_front());
          m_fill++;
          if (m_fill == LEN) begin
            m_mode = 1; m_fill = 0; m_win = 0; m_mis = 0;
            m_zero = 1;
            foreach (seq[i]) if (seq[i]) m_zero = 0;
          end
        end else begin
          m_nb = seq[0] ^ seq[1];
          m_pred = {seq[LEN-1], m_nb};
          seq.push_back(m_nb);
          void'(seq.pop_front());
          m_nerr = int'(m_pred[0] != rx_sym[0]) + int'(m_pred[1] != rx_sym[1]);
          m_sym_err = (m_nerr != 0);
          m_mis += int'(m_sym_err);
          m_win++;
          if (m_mode == 2) begin
            m_err = (m_err + m_nerr > CMAX) ? CMAX : m_err + m_nerr;
            m_sym = (m_sym + 1 > CMAX) ? CMAX : m_sym + 1;
          end
          if (m_mode == 1 && m_win == WIN) begin
            m_mode = (m_mis <= TH && !m_zero) ? 2 : 0;
            m_win = 0; m_mis = 0;
          end else if (m_mode == 2 && m_mis > TH) begin
            m_mode = 0; m_slip = 1; m_win = 0; m_mis = 0;
          end else if (m_mode == 2 && m_win == WIN) begin
            m_win = 0; m_mis = 0;
          end
        end
      end
      if (clear) begin
        m_err = 0;
        m_sym = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_locked",  longint'(locked),    longint'(m_mode == 2));
    chk("cyc_state",   longint'(state),     longint'(m_mode));
    chk("cyc_sym_err", longint'(sym_err),   longint'(m_sym_err));
    chk("cyc_slip",    longint'(slip),      longint'(m_slip));
    chk("cyc_err_cnt", longint'(err_count), m_err);
    chk("cyc_sym_cnt", longint'(sym_count), m_sym);
  end

  // Transmitter source
  bit [21:0] tx;
  bit        force_zero = 1'b0;

  function automatic bit [21:0] step(input bit [21:0] s);
    return {s[20:0], s[21] ^ s[20]};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clk_en = 1'b0; clear = 1'b0; rx_sym = 2'($urandom);
    end
  endtask

  task automatic send(input logic [1:0] x, input bit clr, input int gap);
    idle(gap);
    @(negedge clk);
    clk_en = 1'b1;
    clear  = clr;
    rx_sym = force_zero ? 2'b00 : (tx[1:0] ^ x);
    tx = step(tx);
    @(negedge clk);
    clk_en = 1'b0; clear = 1'b0; rx_sym = 2'($urandom);
  endtask

  task automatic relock(input string tag);
    for (int i = 1; i <= LEN + WIN; i++) begin
      send(2'b00, 1'b0, 2);
      if (i == LEN + WIN - 1) chk({tag, "_early"}, longint'(locked), 0);
    end
    chk({tag, "_locked"}, longint'(locked), 1);
    chk({tag, "_state"},  longint'(state), 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int  rate_tab[4] = '{1000000, 64, 24, 10};
  bit  found, any_lock;
  int  rate;

  initial begin
    tx = 22'h000001;
    #1 reset = 1'b0;
    #20;
    chk("rst_locked",  longint'(locked), 0);
    chk("rst_state",   longint'(state), 0);
    chk("rst_sym_err", longint'(sym_err), 0);
    chk("rst_slip",    longint'(slip), 0);
    chk("rst_err_cnt", longint'(err_count), 0);
    chk("rst_sym_cnt", longint'(sym_count), 0);
    @(negedge clk);
    reset = 1'b1;

    // Clean stream, 1-in-4 enables: lock after 22+256 symbols.
    relock("lock1");
    chk("lock1_err_cnt", longint'(err_count), 0);
    for (int i = 0; i < 40; i++) send(2'b00, 1'b0, 2);
    chk("clean_sym_cnt", longint'(sym_count), 40);
    chk("clean_err_cnt", longint'(err_count), 0);

    // One symbol 2'b11 where truth is 2'b00: two bit errors.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (tx[1:0] == 2'b00) begin
        send(2'b11, 1'b0, 2);
        chk("err2_sym_err", longint'(sym_err), 1);
        chk("err2_err_cnt", longint'(err_count), 2);
        chk("err2_locked",  longint'(locked), 1);
        chk("err2_sym_cnt", longint'(sym_count), 41 + i);
        found = 1;
      end else begin
        send(2'b00, 1'b0, 2);
      end
    end
    chk("err2_found", longint'(found), 1);
    idle(1);
    chk("err2_pulse_end", longint'(sym_err), 0);

    // clear coincident with an error increment wins.
    send(2'b01, 1'b1, 2);
    chk("clr_err_cnt", longint'(err_count), 0);
    chk("clr_sym_cnt", longint'(sym_count), 0);
    chk("clr_sym_err", longint'(sym_err), 1);
    send(2'b00, 1'b0, 2);
    chk("clr_then_cnt", longint'(sym_count), 1);

    // Nine corrupted symbols at the start of a fresh window.
    for (int i = 0; i < 300 && m_win != 0; i++) send(2'b00, 1'b0, 2);
    for (int i = 1; i <= 9; i++) begin
      send(2'b01, 1'b0, 2);
      if (i < 9) begin
        chk("slip_early_slip",   longint'(slip), 0);
        chk("slip_early_locked", longint'(locked), 1);
      end else begin
        chk("slip_pulse",   longint'(slip), 1);
        chk("slip_locked",  longint'(locked), 0);
        chk("slip_state",   longint'(state), 0);
        chk("slip_err_cnt", longint'(err_count), 9);
      end
    end
    idle(1);
    chk("slip_pulse_end", longint'(slip), 0);
    chk("slip_err_keep",  longint'(err_count), 9);
    relock("relock");

    // Slip again, reach QUAL, then reset asynchronously mid-window.
    for (int i = 0; i < 5; i++) send(2'b00, 1'b0, 2);
    for (int i = 0; i < 9; i++) send(2'b01, 1'b0, 2);
    for (int i = 0; i < 30; i++) send(2'b00, 1'b0, 2);
    chk("midq_state",   longint'(state), 1);
    chk("midq_err_cnt", longint'(err_count), 18);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_state",   longint'(state), 0);
    chk("arst_locked",  longint'(locked), 0);
    chk("arst_err_cnt", longint'(err_count), 0);
    chk("arst_sym_cnt", longint'(sym_count), 0);
    chk("arst_sym_err", longint'(sym_err), 0);
    chk("arst_slip",    longint'(slip), 0);
    @(negedge clk);
    reset = 1'b1;
    relock("arst_relock");

    // Randomized segments with varying error density, gaps and clears.
    for (int seg = 0; seg < 8; seg++) begin
      rate = rate_tab[seg % 4];
      for (int i = 0; i < 400; i++) begin
        send(($urandom_range(0, rate - 1) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             $urandom_range(0, 63) == 0, $urandom_range(0, 3));
      end
    end

    // All-zero input never locks; QUAL falls back to FILL each window.
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    force_zero = 1'b1;
    any_lock = 0;
    for (int i = 1; i <= 3 * (LEN + WIN); i++) begin
      send(2'b00, 1'b0, 0);
      if (locked) any_lock = 1;
      if (i == LEN)       chk("zero_qual1",  longint'(state), 1);
      if (i == LEN + WIN) chk("zero_fill1",  longint'(state), 0);
      if (i == 2 * LEN + WIN) chk("zero_qual2", longint'(state), 1);
    end
    chk("zero_never_lock", longint'(any_lock), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
